bp_cfg_boot_sequencer: RTL and testbench



---
 rtl/bp_cfg_link_pkg.sv | 33 +++
 rtl/bp_cfg_write_gen.sv | 64 ++++++
 rtl/bp_cfg_boot_sequencer.sv | 156 +++++++++++++++
 tb/tb_bp_cfg_boot_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_link_pkg.sv
// Shared config-link types: sequencer states, boot register map and the write payload struct.
// The e_ucode state exists only when BP_CFG_UCODE_LOAD_EN is defined.
package bp_cfg_link_pkg;

  typedef enum logic [3:0] {
    e_idle,
    e_freeze,
    e_core_id,
    e_icache,
    e_dcache,
    e_cce_mode,
`ifdef BP_CFG_UCODE_LOAD_EN
    e_ucode,
`endif
    e_unfreeze,
    e_done
  } bp_cfg_state_e;

  localparam logic [15:0] bp_cfg_reg_freeze_gp      = 16'h0002;
  localparam logic [15:0] bp_cfg_reg_core_id_gp     = 16'h0004;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp = 16'h0010;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp = 16'h0011;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp    = 16'h0020;
  localparam logic [15:0] bp_cfg_mem_ucode_base_gp  = 16'h8000;

  // Widest payload; the top resizes to its configured link widths.
  typedef struct packed {
    logic [3:0]  core_id;
    logic [15:0] addr;
    logic [63:0] data;
  } bp_cfg_link_s;

endpackage

// File: rtl/bp_cfg_write_gen.sv
// Combinational decode of sequencer state and counters into the current config write.
// With BP_CFG_UCODE_LOAD_EN, also maps the microcode word index onto the ucode window.
module bp_cfg_write_gen
  import bp_cfg_link_pkg::*;
#(
  parameter int unsigned icache_mode_p  = 1,
  parameter int unsigned dcache_mode_p  = 1,
  parameter int unsigned cce_mode_p     = 1,
  parameter int unsigned lg_ucode_els_p = 8
) (
  input  bp_cfg_state_e             state_i,
  input  logic [3:0]                core_i,
`ifdef BP_CFG_UCODE_LOAD_EN
  input  logic [lg_ucode_els_p-1:0] word_i,
  input  logic [63:0]               ucode_data_i,
`endif
  output bp_cfg_link_s              link_o
);

  always_comb begin
    link_o = '0;
    unique case (state_i)
      e_freeze: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_reg_freeze_gp;
        link_o.data    = 64'd1;
      end
      e_core_id: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_reg_core_id_gp;
        link_o.data    = 64'(core_i);
      end
      e_icache: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_reg_icache_mode_gp;
        link_o.data    = 64'(icache_mode_p);
      end
      e_dcache: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_reg_dcache_mode_gp;
        link_o.data    = 64'(dcache_mode_p);
      end
      e_cce_mode: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_reg_cce_mode_gp;
        link_o.data    = 64'(cce_mode_p);
      end
`ifdef BP_CFG_UCODE_LOAD_EN
      e_ucode: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_mem_ucode_base_gp + 16'(word_i);
        link_o.data    = ucode_data_i;
      end
`endif
      e_unfreeze: begin
        link_o.core_id = core_i;
        link_o.addr    = bp_cfg_reg_freeze_gp;
        link_o.data    = 64'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Post-reset config master: per-core boot writes (freeze, id, cache/CCE modes), then unfreeze all.
// Define BP_CFG_UCODE_LOAD_EN to also stream CCE microcode per core from a sync-read ROM.
module bp_cfg_boot_sequencer
  import bp_cfg_link_pkg::*;
#(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 32,
  parameter int unsigned icache_mode_p    = 1,
  parameter int unsigned dcache_mode_p    = 1,
  parameter int unsigned cce_mode_p       = 1,
  parameter int unsigned ucode_els_p      = 256
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  output logic                          cfg_v_o,
  input  logic                          cfg_ready_i,
  output logic [3:0]                    cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
  output logic [cfg_data_width_p-1:0]   cfg_data_o,
`ifdef BP_CFG_UCODE_LOAD_EN
  output logic [$clog2(ucode_els_p)-1:0] ucode_addr_o,
  input  logic [63:0]                   ucode_data_i,
`endif
  output logic                          busy_o,
  output logic                          done_o
);

  if (num_core_p < 1 || num_core_p > 16) begin : g_bad_num_core
    $error("bp_cfg_boot_sequencer: num_core_p must be in 1..16");
  end

  localparam logic [3:0]  last_core_lp    = 4'(num_core_p - 1);
  localparam int unsigned lg_ucode_els_lp = $clog2(ucode_els_p);

  bp_cfg_state_e state_q, state_d;
  logic [3:0]    core_q, core_d;
  logic          xfer;
  logic          per_core_end;
  bp_cfg_link_s  link;

`ifdef BP_CFG_UCODE_LOAD_EN
  localparam logic [lg_ucode_els_lp-1:0] last_word_lp = lg_ucode_els_lp'(ucode_els_p - 1);
  logic [lg_ucode_els_lp-1:0] word_q, word_d;

  // ROM has one cycle of read latency, so present the next index ahead of the transfer.
  assign ucode_addr_o = word_d;
`endif

  assign cfg_v_o = (state_q != e_idle) && (state_q != e_done);
  assign busy_o  = cfg_v_o;
  assign done_o  = (state_q == e_done);
  assign xfer    = cfg_v_o & cfg_ready_i;

  always_comb begin
    state_d      = state_q;
    core_d       = core_q;
    per_core_end = 1'b0;
`ifdef BP_CFG_UCODE_LOAD_EN
    word_d       = word_q;
`endif
    unique case (state_q)
      e_idle: begin
        if (start_i) begin
          state_d = e_freeze;
          core_d  = '0;
        end
      end
      e_freeze:  if (xfer) state_d = e_core_id;
      e_core_id: if (xfer) state_d = e_icache;
      e_icache:  if (xfer) state_d = e_dcache;
      e_dcache:  if (xfer) state_d = e_cce_mode;
      e_cce_mode: begin
        if (xfer) begin
`ifdef BP_CFG_UCODE_LOAD_EN
          state_d = e_ucode;
          word_d  = '0;
`else
          per_core_end = 1'b1;
`endif
        end
      end
`ifdef BP_CFG_UCODE_LOAD_EN
      e_ucode: begin
        if (xfer) begin
          if (word_q == last_word_lp) begin
            word_d       = '0;
            per_core_end = 1'b1;
          end else begin
            word_d = word_q + lg_ucode_els_lp'(1);
          end
        end
      end
`endif
      e_unfreeze: begin
        if (xfer) begin
          if (core_q == last_core_lp) begin
            state_d = e_done;
            core_d  = '0;
          end else begin
            core_d = core_q + 4'd1;
          end
        end
      end
      e_done:  ;
      default: state_d = e_idle;
    endcase

    if (per_core_end) begin
      if (core_q == last_core_lp) begin
        state_d = e_unfreeze;
        core_d  = '0;
      end else begin
        state_d = e_freeze;
        core_d  = core_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      core_q  <= '0;
`ifdef BP_CFG_UCODE_LOAD_EN
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
`ifdef BP_CFG_UCODE_LOAD_EN
      word_q  <= word_d;
`endif
    end
  end

  bp_cfg_write_gen #(
    .icache_mode_p  (icache_mode_p),
    .dcache_mode_p  (dcache_mode_p),
    .cce_mode_p     (cce_mode_p),
    .lg_ucode_els_p (lg_ucode_els_lp)
  ) u_write_gen (
    .state_i      (state_q),
    .core_i       (core_q),
`ifdef BP_CFG_UCODE_LOAD_EN
    .word_i       (word_q),
    .ucode_data_i (ucode_data_i),
`endif
    .link_o       (link)
  );

  assign cfg_core_id_o = link.core_id;
  assign cfg_addr_o    = cfg_addr_width_p'(link.addr);
  assign cfg_data_o    = cfg_data_width_p'(link.data);

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Directed bench for bp_cfg_boot_sequencer: one-core and two-core instances sharing clock/reset.
`timescale 1ns/1ps
module tb_bp_cfg_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start1, ready1, v1, busy1, done1;
  logic start2, ready2, v2, busy2, done2;
  logic [3:0]  core1, core2;
  logic [15:0] addr1, addr2;
  logic [31:0] data1, data2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

`ifdef BP_CFG_UCODE_LOAD_EN
  localparam int PerCore = 9;
  logic [1:0]  uaddr1, uaddr2;
  logic [63:0] rom1_q, rom2_q;
  always @(posedge clk) begin
    rom1_q <= 64'hA0 + 64'(uaddr1);
    rom2_q <= 64'hA0 + 64'(uaddr2);
  end
`else
  localparam int PerCore = 5;
`endif

  bp_cfg_boot_sequencer #(.num_core_p(1), .ucode_els_p(4)) u_dut1 (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .start_i       (start1),
    .cfg_v_o       (v1),
    .cfg_ready_i   (ready1),
    .cfg_core_id_o (core1),
    .cfg_addr_o    (addr1),
    .cfg_data_o    (data1),
`ifdef BP_CFG_UCODE_LOAD_EN
    .ucode_addr_o  (uaddr1),
    .ucode_data_i  (rom1_q),
`endif
    .busy_o        (busy1),
    .done_o        (done1)
  );

  bp_cfg_boot_sequencer #(.num_core_p(2), .ucode_els_p(4)) u_dut2 (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .start_i       (start2),
    .cfg_v_o       (v2),
    .cfg_ready_i   (ready2),
    .cfg_core_id_o (core2),
    .cfg_addr_o    (addr2),
    .cfg_data_o    (data2),
`ifdef BP_CFG_UCODE_LOAD_EN
    .ucode_addr_o  (uaddr2),
    .ucode_data_i  (rom2_q),
`endif
    .busy_o        (busy2),
    .done_o        (done2)
  );

  typedef struct {
    logic [51:0] w;
    int          cyc;
  } xfer_t;

  xfer_t q1[$];
  xfer_t q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so a negedge sample is exactly what the next edge accepts.
  always @(negedge clk) begin
    if (rst_n && v1 && ready1) q1.push_back('{w: {core1, addr1, data1}, cyc: cyc});
    if (rst_n && v2 && ready2) q2.push_back('{w: {core2, addr2, data2}, cyc: cyc});
  end

  function automatic logic [51:0] ent(input int c, input int a, input int d);
    return {c[3:0], a[15:0], d[31:0]};
  endfunction

  task automatic build_exp(input int ncore, output logic [51:0] exp[$]);
    exp.delete();
    for (int c = 0; c < ncore; c++) begin
      exp.push_back(ent(c, 'h0002, 1));
      exp.push_back(ent(c, 'h0004, c));
      exp.push_back(ent(c, 'h0010, 1));
      exp.push_back(ent(c, 'h0011, 1));
      exp.push_back(ent(c, 'h0020, 1));
`ifdef BP_CFG_UCODE_LOAD_EN
      for (int i = 0; i < 4; i++) exp.push_back(ent(c, 'h8000 + i, 'hA0 + i));
`endif
    end
    for (int c = 0; c < ncore; c++) exp.push_back(ent(c, 'h0002, 0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b0; ready1 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({v1, busy1, done1, core1, addr1, data1} !== 55'd0) begin
      errors++;
      $display("FAIL reset_dut1: v/busy/done/core/addr/data=%b/%b/%b/%h/%h/%h required all 0",
               v1, busy1, done1, core1, addr1, data1);
    end
    checks++;
    if ({v2, busy2, done2, core2, addr2, data2} !== 55'd0) begin
      errors++;
      $display("FAIL reset_dut2: v/busy/done/core/addr/data=%b/%b/%b/%h/%h/%h required all 0",
               v2, busy2, done2, core2, addr2, data2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({v1, busy1, done1} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_start: v/busy/done=%b required 000", {v1, busy1, done1});
    end
  endtask

  task automatic test_single_core();
    logic [51:0] exp[$];
    int n;
    build_exp(1, exp);
    q1.delete();
    ready1 = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++;
    if ({v1, busy1, core1, addr1, data1} !== {2'b11, 4'd0, 16'h0002, 32'd1}) begin
      errors++;
      $display("FAIL single_first_write: v/busy=%b addr=%h data=%h required 11 0002 1",
               {v1, busy1}, addr1, data1);
    end
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q1.size() != exp.size()) begin
      errors++;
      $display("FAIL single_count: got %0d transfers required %0d", q1.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < q1.size(); i++) begin
      checks++;
      if (q1[i].w !== exp[i]) begin
        errors++;
        $display("FAIL single_xfer%0d: got %h required %h", i, q1[i].w, exp[i]);
      end
      checks++;
      if (q1[i].cyc !== q1[0].cyc + i) begin
        errors++;
        $display("FAIL single_b2b%0d: cycle %0d required %0d", i, q1[i].cyc, q1[0].cyc + i);
      end
    end
    checks++;
    if ({v1, busy1, done1} !== 3'b001) begin
      errors++;
      $display("FAIL single_done: v/busy/done=%b required 001", {v1, busy1, done1});
    end
  endtask

  task automatic test_stall_two_core();
    logic [51:0] exp[$];
    logic [51:0] held;
    logic        have_prev;
    int          stalls, n;
    build_exp(2, exp);
    q2.delete();
    have_prev = 1'b0;
    stalls = 0;
    n = 0;
    start2 = 1'b1;
    while (!done2 && n < 400) begin
      ready2 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (have_prev) begin
        checks++;
        if (!v2 || {core2, addr2, data2} !== held) begin
          errors++;
          $display("FAIL stall_hold: v=%b payload=%h required 1 %h", v2, {core2, addr2, data2},
                   held);
        end
      end
      have_prev = v2 && !ready2;
      held = {core2, addr2, data2};
      if (have_prev) stalls++;
      @(posedge clk); #1;
      start2 = 1'b0;
      n++;
    end
    ready2 = 1'b0;
    checks++;
    if (!done2) begin
      errors++;
      $display("FAIL stall_timeout: done=%b required 1", done2);
    end
    checks++;
    if (stalls == 0) begin
      errors++;
      $display("FAIL stall_seen: stalls=%0d required >0", stalls);
    end
    checks++;
    if (q2.size() != exp.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d transfers required %0d", q2.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < q2.size(); i++) begin
      checks++;
      if (q2[i].w !== exp[i]) begin
        errors++;
        $display("FAIL stall_xfer%0d: got %h required %h", i, q2[i].w, exp[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n, cnt;
    cnt = q1.size();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (q1.size() != cnt || {v1, busy1, done1} !== 3'b001) begin
      errors++;
      $display("FAIL start_in_done: count=%0d v/busy/done=%b required %0d 001", q1.size(),
               {v1, busy1, done1}, cnt);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q1.delete();
    ready1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start1 = 1'b1;
      @(negedge clk);
      checks++;
      if ({v1, busy1, core1, addr1, data1} !== {2'b11, 4'd0, 16'h0002, 32'd1}) begin
        errors++;
        $display("FAIL busy_stall%0d: v/busy=%b payload=%h %h %h required 11 0 0002 1", i,
                 {v1, busy1}, core1, addr1, data1);
      end
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    ready1 = 1'b1;
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q1.size() != PerCore + 1) begin
      errors++;
      $display("FAIL start_in_busy_count: got %0d required %0d", q1.size(), PerCore + 1);
    end
    checks++;
    if (q1.size() == 0 || q1[q1.size()-1].w !== ent(0, 'h0002, 0) || !done1) begin
      errors++;
      $display("FAIL start_in_busy_end: done=%b entries=%0d required done 1 ending freeze=0",
               done1, q1.size());
    end
  endtask

  task automatic test_reset_abort();
    int n;
    q2.delete();
    ready2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (q2.size() < PerCore + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ready2 = 1'b0;
    @(negedge clk);
    checks++;
    if ({v2, core2, addr2, data2} !== {1'b1, 4'd1, 16'h0011, 32'd1}) begin
      errors++;
      $display("FAIL abort_position: v=%b core=%h addr=%h data=%h required 1 1 0011 1", v2,
               core2, addr2, data2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({v2, busy2, done2, core2, addr2, data2} !== 55'd0) begin
      errors++;
      $display("FAIL abort_async: v/busy/done/core/addr/data=%b/%b/%b/%h/%h/%h required all 0",
               v2, busy2, done2, core2, addr2, data2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q2.delete();
    ready2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q2.size() == 0 || q2[0].w !== ent(0, 'h0002, 1)) begin
      errors++;
      $display("FAIL abort_restart_first: entries=%0d first=%h required %h", q2.size(),
               (q2.size() > 0) ? q2[0].w : 52'd0, ent(0, 'h0002, 1));
    end
    checks++;
    if (q2.size() != 2 * PerCore + 2 || !done2) begin
      errors++;
      $display("FAIL abort_restart_count: got %0d done=%b required %0d done 1", q2.size(),
               done2, 2 * PerCore + 2);
    end
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_stall_two_core();
    test_start_ignored();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
